// File: rtl/riscv16_prog_loader_if.sv
// Load/run/fetch bus between the host, the core and the program loader.
interface riscv16_prog_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int SLOT_W = 2
);
  logic              ext_we;
  logic [DATA_W-1:0] ext_data;
  logic [SLOT_W-1:0] ext_slot;
  logic              ext_commit;
  logic              run_req;
  logic [SLOT_W-1:0] run_slot;
  logic              halt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   load_len;

  // host/core side
  modport master (
    output ext_we, ext_data, ext_slot, ext_commit, run_req, run_slot, halt, fetch_addr,
    input  fetch_data, cpu_rst_n, busy, done, err, load_len
  );

  // loader side
  modport slave (
    input  ext_we, ext_data, ext_slot, ext_commit, run_req, run_slot, halt, fetch_addr,
    output fetch_data, cpu_rst_n, busy, done, err, load_len
  );
endinterface

// File: rtl/riscv16_prog_loader.sv
// Multi-slot program store with load sequencing, core reset sequencing and
// a registered instruction fetch port that returns HALT_WORD past the program.
module riscv16_prog_loader #(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 8,
  parameter int              NUM_SLOTS  = 4,
  parameter int              RST_CYCLES = 9,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hE001
) (
  input  logic clk,
  input  logic PC_rst,
  riscv16_prog_loader_if.slave bus
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MEM_N  = 1 << (SLOT_W + ADDR_W);
  localparam int CNT_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARM, S_RUN, S_HALTED} state_e;

  state_e                           state_q, state_d;
  logic [SLOT_W-1:0]                wslot_q, wslot_d;
  logic [SLOT_W-1:0]                rslot_q, rslot_d;
  logic [ADDR_W:0]                  wptr_q, wptr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0][ADDR_W:0]   len_q, len_d;
  logic                             cpu_rst_n_q, cpu_rst_n_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;
  logic [ADDR_W:0]                  load_len_q, load_len_d;
  logic [DATA_W-1:0]                fetch_data_q, fetch_data_d;

  logic [DATA_W-1:0]                mem [MEM_N];
  logic                             mem_we;
  logic [SLOT_W+ADDR_W-1:0]         mem_waddr;
  logic [ADDR_W:0]                  wptr_nxt;
  logic [ADDR_W:0]                  fetch_len;

  // Control: next state, write pointer, per-slot lengths, sticky error, core reset
  always_comb begin
    state_d     = state_q;
    wslot_d     = wslot_q;
    rslot_d     = rslot_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    cpu_rst_n_d = cpu_rst_n_q;
    err_d       = err_q;
    load_len_d  = load_len_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    wptr_nxt    = wptr_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        // a new load always wins over a same-cycle run request
        if (bus.ext_we) begin
          wslot_d   = bus.ext_slot;
          mem_we    = 1'b1;
          mem_waddr = {bus.ext_slot, {ADDR_W{1'b0}}};
          wptr_d    = (ADDR_W+1)'(1);
          state_d   = S_LOAD;
        end else if (bus.run_req) begin
          if (len_q[bus.run_slot] != '0) begin
            rslot_d     = bus.run_slot;
            err_d       = 1'b0;
            cnt_d       = CNT_INIT;
            cpu_rst_n_d = 1'b0;
            state_d     = S_ARM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // words beyond the slot depth are dropped; the pointer saturates at DEPTH
        if (bus.ext_we) begin
          if (wptr_q < DEPTH_L) begin
            mem_we    = 1'b1;
            mem_waddr = {wslot_q, wptr_q[ADDR_W-1:0]};
            wptr_nxt  = wptr_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        wptr_d = wptr_nxt;
        if (bus.ext_commit) begin
          len_d[wslot_q] = wptr_nxt;
          load_len_d     = wptr_nxt;
          state_d        = S_IDLE;
        end
      end
      S_ARM: begin
        if (bus.ext_we) err_d = 1'b1;
        if (cnt_q == '0) begin
          cpu_rst_n_d = 1'b1;
          state_d     = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (bus.ext_we) err_d = 1'b1;
        if (bus.halt) state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_ARM) || (state_d == S_RUN);
    done_d = (state_d == S_HALTED);
  end

  // Fetch: out-of-program addresses read back as the halt word
  always_comb begin
    fetch_len    = len_q[rslot_q];
    fetch_data_d = HALT_WORD;
    if ({1'b0, bus.fetch_addr} < fetch_len)
      fetch_data_d = mem[{rslot_q, bus.fetch_addr}];
  end

  // Program storage; contents survive reset, lengths gate visibility
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.ext_data;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge PC_rst) begin
    if (!PC_rst) begin
      state_q      <= S_IDLE;
      wslot_q      <= '0;
      rslot_q      <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      cpu_rst_n_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      load_len_q   <= '0;
      fetch_data_q <= HALT_WORD;
    end else begin
      state_q      <= state_d;
      wslot_q      <= wslot_d;
      rslot_q      <= rslot_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      load_len_q   <= load_len_d;
      fetch_data_q <= fetch_data_d;
    end
  end

  assign bus.fetch_data = fetch_data_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.load_len   = load_len_q;
endmodule

// File: tb/tb_riscv16_prog_loader.sv
// Directed sequence with random program words, checked against a slot/length model.
module tb_riscv16_prog_loader;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  localparam int HW = 'hE001;

  logic clk;
  logic PC_rst;
  int   nchk = 0;
  int   nerr = 0;

  logic [15:0] m_mem [4][DEPTH];
  int          m_len [4];
  int          m_rslot;

  riscv16_prog_loader_if #(.DATA_W(16), .ADDR_W(AW), .SLOT_W(2)) bus ();

  riscv16_prog_loader #(.DATA_W(16), .ADDR_W(AW), .NUM_SLOTS(4), .RST_CYCLES(9),
                        .HALT_WORD(16'hE001)) dut (
    .clk(clk), .PC_rst(PC_rst), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_fetch(int a);
    if (a < m_len[m_rslot]) return int'(m_mem[m_rslot][a]);
    return HW;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < 4; s++) m_len[s] = 0;
    m_rslot = 0;
  endtask

  task automatic do_reset();
    PC_rst = 1'b0;
    tick();
    PC_rst = 1'b1;
    clear_model();
    tick();
  endtask

  // Stream n words into a slot; optional commit on the last word and
  // optional run request alongside the first word.
  task automatic load(input int slot, input int n, input bit commit_last,
                      input bit last_halt, input int run_s);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = (last_halt && i == n - 1) ? 16'hE001 : 16'($urandom);
      bus.ext_we     = 1'b1;
      bus.ext_slot   = 2'(slot);
      bus.ext_data   = w;
      bus.ext_commit = commit_last && (i == n - 1);
      if (i == 0 && run_s >= 0) begin
        bus.run_req  = 1'b1;
        bus.run_slot = 2'(run_s);
      end
      if (i < DEPTH) m_mem[slot][i] = w;
      tick();
      bus.run_req = 1'b0;
      if (i == 0 && n > 1) chk("load_busy", 32'(bus.busy), 1);
    end
    bus.ext_we     = 1'b0;
    bus.ext_commit = 1'b0;
    if (!commit_last) begin
      bus.ext_commit = 1'b1;
      tick();
      bus.ext_commit = 1'b0;
    end
    m_len[slot] = (n > DEPTH) ? DEPTH : n;
    chk($sformatf("load_len_s%0d", slot), 32'(bus.load_len), m_len[slot]);
    chk("load_idle_busy", 32'(bus.busy), 0);
  endtask

  task automatic run_pulse(input int s);
    bus.run_req  = 1'b1;
    bus.run_slot = 2'(s);
    tick();
    bus.run_req = 1'b0;
    if (m_len[s] != 0) m_rslot = s;
  endtask

  task automatic wait_run();
    int n = 0;
    while (bus.cpu_rst_n !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("arm_cycles", n, 9);
  endtask

  task automatic fetch_chk(input int a);
    int e;
    e = exp_fetch(a);
    bus.fetch_addr = AW'(a);
    tick();
    chk($sformatf("fetch_s%0d_a%0d", m_rslot, a), 32'(bus.fetch_data), e);
  endtask

  task automatic do_halt();
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    chk("halt_done", 32'(bus.done), 1);
    chk("halt_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    int old;
    PC_rst = 1'b0;
    bus.ext_we = 1'b0; bus.ext_data = '0; bus.ext_slot = '0; bus.ext_commit = 1'b0;
    bus.run_req = 1'b0; bus.run_slot = '0; bus.halt = 1'b0; bus.fetch_addr = '0;
    clear_model();
    repeat (3) tick();

    // reset values
    chk("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    chk("rst_fetch", 32'(bus.fetch_data), HW);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_load_len", 32'(bus.load_len), 0);
    PC_rst = 1'b1;
    tick();

    // run of a never-loaded slot
    run_pulse(1);
    chk("bad_run_err", 32'(bus.err), 1);
    chk("bad_run_busy", 32'(bus.busy), 0);
    chk("bad_run_done", 32'(bus.done), 0);
    tick();
    chk("bad_run_cpu_rst_n", 32'(bus.cpu_rst_n), 0);

    // five-word program in slot 2, run, fetch, halt
    load(2, 5, 1'b0, 1'b1, -1);
    chk("err_sticky", 32'(bus.err), 1);
    run_pulse(2);
    chk("arm_busy", 32'(bus.busy), 1);
    chk("arm_err_clr", 32'(bus.err), 0);
    chk("arm_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    wait_run();
    chk("run_busy", 32'(bus.busy), 1);
    for (int a = 0; a < 5; a++) fetch_chk(a);
    fetch_chk(5);
    fetch_chk(int'($urandom_range(6, DEPTH - 1)));
    fetch_chk(2);
    old = exp_fetch(2);
    bus.fetch_addr = AW'(0);
    #3;
    chk("fetch_registered", 32'(bus.fetch_data), old);
    tick();
    chk("fetch_latency", 32'(bus.fetch_data), exp_fetch(0));
    do_halt();
    chk("halted_cpu_rst_n", 32'(bus.cpu_rst_n), 1);

    // overflow: DEPTH+3 words
    do_reset();
    load(1, DEPTH + 3, 1'b0, 1'b0, -1);
    chk("ovf_err", 32'(bus.err), 1);
    run_pulse(1);
    wait_run();
    fetch_chk(DEPTH - 1);
    fetch_chk(0);
    fetch_chk(DEPTH - 2);

    // two slots, switch run slot from HALTED
    do_reset();
    load(0, 3, 1'b0, 1'b0, -1);
    load(3, 2, 1'b1, 1'b0, -1);
    run_pulse(3);
    wait_run();
    fetch_chk(2);
    fetch_chk(1);
    bus.ext_we = 1'b1; bus.ext_slot = 2'd3; bus.ext_data = 16'($urandom);
    tick();
    bus.ext_we = 1'b0;
    chk("run_we_err", 32'(bus.err), 1);
    chk("run_we_busy", 32'(bus.busy), 1);
    chk("run_we_done", 32'(bus.done), 0);
    fetch_chk(0);
    do_halt();
    run_pulse(0);
    chk("rerun_err_clr", 32'(bus.err), 0);
    wait_run();
    fetch_chk(2);
    fetch_chk(3);
    do_halt();

    // load and run request in the same idle cycle: load wins
    load(1, 2, 1'b0, 1'b0, -1);
    load(2, 3, 1'b0, 1'b0, 0);
    chk("sim_done", 32'(bus.done), 0);
    fetch_chk(1);

    // reset during the 4th ARM cycle
    run_pulse(0);
    repeat (3) tick();
    #2;
    PC_rst = 1'b0;
    #1;
    chk("arm_rst_cpu_rst_n", 32'(bus.cpu_rst_n), 0);
    chk("arm_rst_busy", 32'(bus.busy), 0);
    chk("arm_rst_done", 32'(bus.done), 0);
    chk("arm_rst_load_len", 32'(bus.load_len), 0);
    chk("arm_rst_fetch", 32'(bus.fetch_data), HW);
    tick();
    PC_rst = 1'b1;
    clear_model();
    tick();
    for (int a = 0; a < 3; a++) fetch_chk(a);
    run_pulse(2);
    chk("post_rst_run_err", 32'(bus.err), 1);
    chk("post_rst_run_busy", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
